// File: rtl/pio_uart_pkg.sv
// Shared types and constants for the PIO UART receive path.
package pio_uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_e;

   localparam int MIN_DIV        = 4;
   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/pio_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
module pio_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   assign dout_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/pio_uart_rx.sv
// 8N1-style UART receiver: synchronizer, mid-bit sampling FSM and an output FIFO.
module pio_uart_rx
   import pio_uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [DIV_W-1:0]     div,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dout,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clr,
   output logic                 busy,
   output logic [2:0]           dbg_state
);

   localparam int BW = $clog2(DATA_BITS + 1);

   uart_state_e          state_q, state_d;
   logic                 sync1_q, rx_s_q, rx_q;
   logic [DIV_W-1:0]     bit_len_q, bit_len_d, cnt_q, cnt_d, div_eff;
   logic [BW-1:0]        bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] sr_q, sr_d;
   logic                 fe_q, fe_d, ovr_q, ovr_d;
   logic                 push, tick, fifo_full, fifo_empty, drop;

   assign div_eff = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
   assign tick    = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_len_d = bit_len_q;
      bitcnt_d  = bitcnt_q;
      sr_d      = sr_q;
      push      = 1'b0;
      fe_d      = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (rx_q && !rx_s_q) begin
               state_d   = START;
               bit_len_d = div_eff;
               cnt_d     = (div_eff >> 1) - 1'b1;
            end
            START: if (tick) begin
               if (!rx_s_q) begin
                  state_d  = DATA;
                  cnt_d    = bit_len_q - 1'b1;
                  bitcnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else cnt_d = cnt_q - 1'b1;
            DATA: if (tick) begin
               sr_d     = {rx_s_q, sr_q[DATA_BITS-1:1]};
               cnt_d    = bit_len_q - 1'b1;
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
            end else cnt_d = cnt_q - 1'b1;
            STOP: if (tick) begin
               if (rx_s_q) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end
            end else cnt_d = cnt_q - 1'b1;
            // Hold here until the line returns high so a break cannot look like a new start.
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign drop  = push && fifo_full && !(ready && valid);
   assign ovr_d = drop ? 1'b1 : (clr ? 1'b0 : ovr_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_q      <= 1'b1;
         bit_len_q <= DIV_W'(MIN_DIV);
         cnt_q     <= '0;
         bitcnt_q  <= '0;
         sr_q      <= '0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= rx;
         rx_s_q    <= sync1_q;
         rx_q      <= rx_s_q;
         bit_len_q <= bit_len_d;
         cnt_q     <= cnt_d;
         bitcnt_q  <= bitcnt_d;
         sr_q      <= sr_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
      end
   end

   pio_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (push),
      .din_i   (sr_d),
      .pop_i   (ready),
      .dout_o  (dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o ()
   );

   assign valid     = !fifo_empty;
   assign frame_err = fe_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pio_uart_rx.sv
// Directed bench for pio_uart_rx: serial driver, FIFO-output scoreboard, summary.
module tb_pio_uart_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = 16'd8;
  logic        rx = 1'b1;
  logic [7:0]  dout;
  logic        valid;
  logic        ready = 1'b1;
  logic        frame_err;
  logic        overrun;
  logic        clr = 1'b0;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  pio_uart_rx dut (
    .clk(clk), .reset(reset), .en(en), .div(div), .rx(rx),
    .dout(dout), .valid(valid), .ready(ready), .frame_err(frame_err),
    .overrun(overrun), .clr(clr), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, LSB-first data, then the stop level held for stop_len bit periods.
  task automatic send_frame(input logic [7:0] b, input int d, input logic stop_val, input int stop_len);
    rx = 1'b0;
    wait_clk(d);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(d);
    end
    rx = stop_val;
    wait_clk(d * stop_len);
  endtask

  task automatic send_byte(input logic [7:0] b, input int d);
    exp_q.push_back(b);
    send_frame(b, d, 1'b1, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_clk(1);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every accepted output byte must match the queue head.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", dout);
      end else begin
        check("rx_byte", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    int fe0;
    wait_clk(3);
    check("rst_valid", valid, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    en = 1'b1;
    wait_clk(4);

    // single byte at 8 clk/bit
    send_byte(8'h30, 8);
    wait_clk(4);
    check("t1_busy_low", busy, 0);
    wait_drain("t1_drain");
    check("t1_no_fe", fe_cnt, 0);

    // ten back-to-back frames
    for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i), 8);
    wait_drain("t2_drain");
    check("t2_no_fe", fe_cnt, 0);
    check("t2_no_overrun", overrun, 0);

    // overflow the 4-deep FIFO while stalled
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h41 + 8'(i));
      send_frame(8'h41 + 8'(i), 8, 1'b1, 1);
    end
    check("t3_overrun_set", overrun, 1);
    check("t3_valid_held", valid, 1);
    check("t3_head", dout, 8'h41);
    ready = 1'b1;
    wait_drain("t3_drain");
    wait_clk(2);
    check("t3_empty", valid, 0);
    check("t3_overrun_sticky", overrun, 1);
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);

    // 3-cycle glitch with a 16 clk bit period
    div = 16'd16;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(40);
    check("t4_idle", dbg_state, 0);
    check("t4_no_fe", fe_cnt, 0);
    check("t4_no_byte", valid, 0);
    div = 16'd8;

    // stop bit held low: one frame_err pulse, BREAK until line idles
    fe0 = fe_cnt;
    send_frame(8'h55, 8, 1'b0, 2);
    check("t5_fe_pulse", fe_cnt, fe0 + 1);
    check("t5_in_break", dbg_state, 4);
    check("t5_no_byte", valid, 0);
    rx = 1'b1;
    wait_clk(5);
    check("t5_idle", dbg_state, 0);
    send_byte(8'hA5, 8);
    wait_drain("t5_drain");
    check("t5_fe_total", fe_cnt, fe0 + 1);

    // enable dropped mid-data
    rx = 1'b0;
    wait_clk(8);
    rx = 1'b1;
    wait_clk(20);
    check("t6_busy_mid", busy, 1);
    en = 1'b0;
    wait_clk(2);
    check("t6_en_abort", busy, 0);
    wait_clk(80);
    en = 1'b1;
    wait_clk(2);
    send_byte(8'h7E, 8);
    wait_drain("t6_drain");

    // async reset mid-frame with a byte waiting in the FIFO
    ready = 1'b0;
    send_frame(8'h11, 8, 1'b1, 1);
    check("t6_pre_valid", valid, 1);
    rx = 1'b0;
    wait_clk(20);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_dout", dout, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_state", dbg_state, 0);
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    ready = 1'b1;
    wait_clk(10);
    check("t6_fifo_empty", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
